// File: rtl/apb_interconnect_pkg.sv
// Shared types for the APB interconnect: FSM state encoding and slave index type.
package apb_interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_ic_state_e;

    localparam int MAX_SLAVES  = 16;
    localparam int SLAVE_IDX_W = $clog2(MAX_SLAVES);

    typedef logic [SLAVE_IDX_W-1:0] slave_idx_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: flags a map hit and returns the lowest matching slave index.
module apb_addr_decoder
    import apb_interconnect_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base [N_SLAVES],
    input  logic [ADDR_W-1:0] mask [N_SLAVES],
    output logic              hit,
    output slave_idx_t        idx
);

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & mask[i]) == base[i]) begin
                hit = 1'b1;
                idx = slave_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/apb_interconnect.sv
// APB fabric: registers one upstream transfer, decodes it and replays it on a single slave.
// Optional ACCESS-phase timeout is enabled by defining APB_INTERCONNECT_TIMEOUT_EN.
module apb_interconnect
    import apb_interconnect_pkg::*;
#(
    parameter int                N_SLAVES       = 4,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [N_SLAVES] =
        '{32'h0000_0000, 32'h1000_0000, 32'h1000_1000, 32'h2000_0000},
    parameter logic [ADDR_W-1:0] SLAVE_MASK [N_SLAVES] =
        '{32'hFFF0_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
    parameter int                TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_psel,
    input  logic                       s_penable,
    input  logic                       s_pwrite,
    input  logic [ADDR_W-1:0]          s_paddr,
    input  logic [DATA_W-1:0]          s_pwdata,
    input  logic [DATA_W/8-1:0]        s_pwstrb,
    output logic                       s_pready,
    output logic                       s_pslverr,
    output logic [DATA_W-1:0]          s_prdata,
    output logic [N_SLAVES-1:0]        m_psel,
    output logic                       m_penable,
    output logic                       m_pwrite,
    output logic [ADDR_W-1:0]          m_paddr,
    output logic [DATA_W-1:0]          m_pwdata,
    output logic [DATA_W/8-1:0]        m_pwstrb,
    input  logic [N_SLAVES-1:0]        m_pready,
    input  logic [N_SLAVES-1:0]        m_pslverr,
    input  logic [N_SLAVES*DATA_W-1:0] m_prdata,
    output apb_ic_state_e              dbg_state
);

    if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("apb_interconnect: unsupported parameter set");
    end

    // Handshake: a transfer starts when psel=1 and penable=0 while idle; it ends in the
    // single cycle where pready=1 (upstream) or where the selected slave's pready=1 in ACCESS.

    apb_ic_state_e      state_q, state_d;
    slave_idx_t         sel_q, sel_d;
    logic               dec_hit;
    slave_idx_t         dec_idx;
    logic [ADDR_W-1:0]  dec_mask;
    logic [ADDR_W-1:0]  map_base [N_SLAVES];
    logic [ADDR_W-1:0]  map_mask [N_SLAVES];
    logic               sel_ready;
    logic               sel_slverr;
    logic [DATA_W-1:0]  sel_rdata;
    logic [N_SLAVES-1:0] psel_d;
    logic               resp_err_d;
    logic [DATA_W-1:0]  resp_data_d;
    logic               load_cmd;
    logic               timeout_hit;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_map
        assign map_base[g] = SLAVE_BASE[g];
        assign map_mask[g] = SLAVE_MASK[g];
    end

    apb_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W)
    ) u_decoder (
        .addr (s_paddr),
        .base (map_base),
        .mask (map_mask),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Pick the response of the active slave and the mask of the freshly decoded one.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        dec_mask   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == slave_idx_t'(i)) begin
                sel_ready  = m_pready[i];
                sel_slverr = m_pslverr[i];
                sel_rdata  = m_prdata[i*DATA_W +: DATA_W];
            end
            if (dec_idx == slave_idx_t'(i)) begin
                dec_mask = SLAVE_MASK[i];
            end
        end
    end

`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts unanswered ACCESS cycles; the limit is hit on the cycle the count would reach TIMEOUT_CYCLES.
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state_q != ACCESS && state_d == ACCESS) begin
            to_cnt <= '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        resp_err_d  = 1'b0;
        resp_data_d = '0;
        load_cmd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    if (dec_hit) begin
                        state_d  = SETUP;
                        sel_d    = dec_idx;
                        load_cmd = 1'b1;
                    end else begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A pready in the limit cycle still wins over the timeout.
                if (sel_ready) begin
                    state_d     = RESP;
                    resp_err_d  = sel_slverr;
                    resp_data_d = (sel_slverr || m_pwrite) ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_d    = RESP;
                    resp_err_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        psel_d = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            psel_d[i] = ((state_d == SETUP) || (state_d == ACCESS)) && (sel_d == slave_idx_t'(i));
        end
    end

    // Outputs are registered from the next-state view so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            s_pready  <= 1'b0;
            s_pslverr <= 1'b0;
            s_prdata  <= '0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pwstrb  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            s_pready  <= (state_d == RESP);
            s_pslverr <= resp_err_d;
            s_prdata  <= resp_data_d;
            m_psel    <= psel_d;
            m_penable <= (state_d == ACCESS);
            if (load_cmd) begin
                m_pwrite <= s_pwrite;
                m_paddr  <= s_paddr & ~dec_mask;
                m_pwdata <= s_pwdata;
                m_pwstrb <= s_pwstrb;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_interconnect.sv
// Bench for apb_interconnect: scripted upstream master and slaves, per-cycle expected queue.
module tb_apb_interconnect;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_1000, 32'h2000_0000};
    localparam logic [31:0] MASK [N] = '{32'hFFF0_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_psel, s_penable, s_pwrite;
    logic [31:0]   s_paddr, s_pwdata;
    logic [3:0]    s_pwstrb;
    logic          s_pready, s_pslverr;
    logic [31:0]   s_prdata;
    logic [N-1:0]  m_psel;
    logic          m_penable, m_pwrite;
    logic [31:0]   m_paddr, m_pwdata;
    logic [3:0]    m_pwstrb;
    logic [N-1:0]  m_pready, m_pslverr;
    logic [N*32-1:0] m_prdata;
    logic [1:0]    dbg_state;

    apb_interconnect #(
        .N_SLAVES       (N),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_pwstrb  (s_pwstrb),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .s_prdata  (s_prdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_pwstrb  (m_pwstrb),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .m_prdata  (m_prdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        shared;
        logic [3:0]  psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pwstrb;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    logic [3:0]  mon_psel;
    logic [31:0] mon_paddr, mon_pwdata, mon_prdata;
    logic [3:0]  mon_pwstrb;
    logic        mon_pslverr;
    int          mon_lat;
    int          setup_cyc;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m_psel",    32'(m_psel),    32'(e.psel));
            check("m_penable", 32'(m_penable), 32'(e.penable));
            check("s_pready",  32'(s_pready),  32'(e.pready));
            check("s_pslverr", 32'(s_pslverr), 32'(e.pslverr));
            check("s_prdata",  s_prdata,       e.prdata);
            if (e.shared) begin
                check("m_paddr",  m_paddr,         e.paddr);
                check("m_pwrite", 32'(m_pwrite),   32'(e.pwrite));
                check("m_pwdata", m_pwdata,        e.pwdata);
                check("m_pwstrb", 32'(m_pwstrb),   32'(e.pwstrb));
            end
        end
        if (m_psel != '0 && !m_penable) begin
            mon_psel   = m_psel;
            mon_paddr  = m_paddr;
            mon_pwdata = m_pwdata;
            mon_pwstrb = m_pwstrb;
        end
        if (s_pready) begin
            mon_prdata  = s_prdata;
            mon_pslverr = s_pslverr;
            mon_lat     = cyc - setup_cyc;
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    function automatic exp_t quiet_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic slave_noise();
        m_pready  = 4'($urandom);
        m_pslverr = 4'($urandom);
        for (int i = 0; i < N; i++) m_prdata[i*32 +: 32] = $urandom;
    endtask

    task automatic master_noise();
        s_psel    = 1'($urandom);
        s_penable = 1'($urandom);
        s_pwrite  = 1'($urandom);
        s_paddr   = $urandom;
        s_pwdata  = $urandom;
        s_pwstrb  = 4'($urandom);
    endtask

    // Upstream activity that is never a transfer start.
    task automatic master_idle_noise();
        master_noise();
        if (s_psel) s_penable = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            master_idle_noise();
            slave_noise();
            exp_q.push_back(quiet_exp());
        end
    endtask

    // One upstream transfer; hang keeps the slave silent, abort_at raises rst in that cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input logic slv_err,
                        input logic [31:0] slv_rdata, input bit hang, input int abort_at);
        int   idx;
        int   resp_c;
        exp_t e;
        idx = model_decode(addr);
        if (idx < 0)   resp_c = 1;
        else if (hang) resp_c = 2 + TIMEOUT;
        else           resp_c = 3 + waits;
        for (int c = 0; c <= resp_c; c++) begin
            @(posedge clk); #1;
            master_noise();
            slave_noise();
            if (c == 0) begin
                s_psel    = 1'b1;
                s_penable = 1'b0;
                s_pwrite  = wr;
                s_paddr   = addr;
                s_pwdata  = wdata;
                s_pwstrb  = strb;
                setup_cyc = cyc;
            end
            if (idx >= 0 && c >= 2 && c < resp_c) begin
                m_pready[idx]            = !hang && (c == resp_c - 1);
                m_pslverr[idx]           = slv_err;
                m_prdata[idx*32 +: 32]   = slv_rdata;
            end
            e = quiet_exp();
            if (idx >= 0 && c >= 1 && c < resp_c) begin
                e.shared  = 1'b1;
                e.psel    = 4'(1) << idx;
                e.penable = (c >= 2);
                e.pwrite  = wr;
                e.paddr   = addr & ~MASK[idx];
                e.pwdata  = wdata;
                e.pwstrb  = strb;
            end
            if (c == resp_c) begin
                e.pready  = 1'b1;
                e.pslverr = (idx < 0) || hang || slv_err;
                e.prdata  = ((idx < 0) || hang || slv_err || wr) ? 32'h0 : slv_rdata;
            end
            exp_q.push_back(e);
            if (c == abort_at) begin
                rst = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return {12'h000, 20'($urandom)};
            1:       return 32'h1000_0000 | 32'($urandom_range(0, 32'hFFF));
            2:       return 32'h1000_1000 | 32'($urandom_range(0, 32'hFFF));
            3:       return 32'h2000_0000 | 32'($urandom_range(0, 32'hFFFF));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        exp_t z;
        rst = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pwstrb = '0;
        m_pready = '0; m_pslverr = '0; m_prdata = '0;
        setup_cyc = 0; mon_lat = 0;

        z = quiet_exp();
        z.shared = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            master_noise();
            slave_noise();
            exp_q.push_back(z);
        end
        rst = 1'b0;
        idle(2);

        // zero-wait read from slave0
        xfer(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, -1);
        @(negedge clk); #1;
        check("t1_psel",   32'(mon_psel),    32'h1);
        check("t1_paddr",  mon_paddr,        32'h40);
        check("t1_prdata", mon_prdata,       32'hDEAD_BEEF);
        check("t1_lat",    32'(mon_lat),     32'd3);
        check("t1_err",    32'(mon_pslverr), 32'd0);
        idle(1);

        // write to slave2 with two wait states
        xfer(32'h1000_1008, 1'b1, 32'h1234_5678, 4'b0011, 2, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);
        @(negedge clk); #1;
        check("t2_psel",   32'(mon_psel),    32'h4);
        check("t2_paddr",  mon_paddr,        32'h8);
        check("t2_pwdata", mon_pwdata,       32'h1234_5678);
        check("t2_pwstrb", 32'(mon_pwstrb),  32'h3);
        check("t2_lat",    32'(mon_lat),     32'd5);
        check("t2_prdata", mon_prdata,       32'h0);

        // unmapped read
        xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0, -1);
        @(negedge clk); #1;
        check("t3_lat",    32'(mon_lat),     32'd1);
        check("t3_err",    32'(mon_pslverr), 32'd1);
        check("t3_prdata", mon_prdata,       32'h0);

        // back-to-back: slave1 with error, then slave3
        xfer(32'h1000_0004, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h5555_AAAA, 1'b0, -1);
        @(negedge clk); #1;
        check("t4a_psel",  32'(mon_psel),    32'h2);
        check("t4a_err",   32'(mon_pslverr), 32'd1);
        xfer(32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, -1);
        @(negedge clk); #1;
        check("t4b_psel",  32'(mon_psel),    32'h8);
        check("t4b_paddr", mon_paddr,        32'h10);
        check("t4b_err",   32'(mon_pslverr), 32'd0);
        check("t4b_prdata", mon_prdata,      32'h0BAD_CAFE);
        check("t4b_lat",   32'(mon_lat),     32'd3);

        // reset during ACCESS of a write to slave0
        xfer(32'h0000_0100, 1'b1, 32'hA5A5_A5A5, 4'hF, 3, 1'b0, 32'h0, 1'b0, 3);
        @(posedge clk); #1;
        rst = 1'b0;
        master_idle_noise();
        slave_noise();
        exp_q.push_back(z);
        idle(3);
        xfer(32'h0000_0200, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_F00D, 1'b0, -1);
        @(negedge clk); #1;
        check("t5_prdata", mon_prdata,       32'hCAFE_F00D);
        check("t5_lat",    32'(mon_lat),     32'd4);

`ifdef APB_INTERCONNECT_TIMEOUT_EN
        // slave never ready, and a pready landing exactly on the limit cycle
        xfer(32'h0000_0080, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h1111_2222, 1'b1, -1);
        @(negedge clk); #1;
        check("t6_lat",    32'(mon_lat),     32'd10);
        check("t6_err",    32'(mon_pslverr), 32'd1);
        check("t6_prdata", mon_prdata,       32'h0);
        xfer(32'h0000_0084, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 32'h3333_4444, 1'b0, -1);
        @(negedge clk); #1;
        check("t7_err",    32'(mon_pslverr), 32'd0);
        check("t7_prdata", mon_prdata,       32'h3333_4444);
`endif

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            bit hang;
            hang = TO_EN && ($urandom_range(0, 15) == 0);
            xfer(rand_addr(), 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 7),
                 1'($urandom_range(0, 3) == 0), $urandom, hang, -1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk); #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_interconnect.md
Name: apb_interconnect

Overview:
Parametrised APB fabric sitting between core_top's APB master port and N APB slaves (RAM, peripherals).
- Registers each upstream transfer and decodes it against a parameter address map.
- Replays the transfer as a fresh SETUP/ACCESS on exactly one slave, with the address rebased to a slave-local offset.
- Unmapped accesses complete with an error and never reach any slave.

Parameters:
N_SLAVES, 4, number of downstream slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
SLAVE_BASE, {32'h0000_0000, 32'h1000_0000, 32'h1000_1000, 32'h2000_0000}, base address per slave, index 0 first
SLAVE_MASK, {32'hFFF0_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}, decode mask per slave
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_psel, s_penable, s_pwrite  in  1 each  upstream APB control
s_paddr  in  ADDR_W  upstream address
s_pwdata  in  DATA_W  upstream write data
s_pwstrb  in  DATA_W/8  upstream write strobe
s_pready, s_pslverr  out  1 each  upstream response
s_prdata  out  DATA_W  upstream read data
m_psel  out  N_SLAVES  one-hot slave select
m_penable, m_pwrite  out  1 each  shared downstream control
m_paddr  out  ADDR_W  shared downstream offset address
m_pwdata  out  DATA_W  shared downstream write data
m_pwstrb  out  DATA_W/8  shared downstream strobe
m_pready, m_pslverr  in  N_SLAVES each  per-slave response
m_prdata  in  N_SLAVES*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W]

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk. All outputs are registered.
- Reset values: every output is 0; FSM is in IDLE; timeout counter is 0.
- Reset asserted mid-transfer aborts it. No s_pready is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Trigger: s_psel=1 and s_penable=0.
  - On trigger, capture paddr, pwrite, pwdata and pwstrb.
  - Decode: hit[i] = ((paddr & SLAVE_MASK[i]) == SLAVE_BASE[i]). Lowest hitting index wins.
  - Hit: go to SETUP with sel=i.
  - Miss: go to RESP with err=1 and rdata=0.
- SETUP (one cycle):
  - m_psel[sel]=1, m_penable=0.
  - m_paddr = captured paddr & ~SLAVE_MASK[sel].
  - Then go to ACCESS.
- ACCESS:
  - m_psel[sel]=1, m_penable=1.
  - When m_pready[sel]=1: capture m_prdata[sel] and m_pslverr[sel], drop m_psel and m_penable, go to RESP.
- RESP (one cycle):
  - s_pready=1.
  - s_prdata = captured data, or 0 on error or write.
  - s_pslverr = captured error.
  - Then go to IDLE.
- Latency:
  - Mapped transfer with a zero-wait slave: s_pready asserts 3 cycles after the upstream setup cycle.
  - Unmapped transfer: s_pready asserts 1 cycle after the setup cycle.
- Back-to-back: a new upstream setup in the cycle after RESP is accepted with no bubble.
- All s_* inputs are ignored outside IDLE.
- m_* shared outputs hold stable from SETUP through ACCESS.
- Inputs from unselected slaves are ignored.
- An m_pready seen in SETUP is ignored.

Optional Feature:
Macro: APB_INTERCONNECT_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with m_pready[sel]=0.
  - When the counter reaches TIMEOUT_CYCLES: drop m_psel and m_penable, go to RESP with err=1 and rdata=0.
  - A pready arriving in the same cycle as the limit takes priority and gives a normal completion.
- Undefined: no counter logic; ACCESS waits indefinitely.

Decomposition:
- Package apb_interconnect_pkg holds:
  - state enum apb_ic_state_e {IDLE, SETUP, ACCESS, RESP};
  - constant MAX_SLAVES=16;
  - typedef for the slave index, width $clog2(MAX_SLAVES).
- Sub-module apb_addr_decoder: combinational; inputs are the address and the map; outputs are hit (1 bit) and the priority-encoded index.

Test Plan:
- Read 0x0000_0040 with slave0 returning 0xDEAD_BEEF, zero-wait -> m_psel=4'b0001, m_paddr=0x40, s_prdata=0xDEAD_BEEF, s_pready 3 cycles after setup, s_pslverr=0.
- Write 0x1000_1008, data 0x1234_5678, strobe 4'b0011, slave2 inserts 2 wait states -> m_psel=4'b0100, m_paddr=0x8, m_pwdata and m_pwstrb forwarded unchanged, s_pready 5 cycles after setup.
- Read 0x3000_0000 (unmapped) -> m_psel stays 0, s_pready 1 cycle after setup, s_pslverr=1, s_prdata=0.
- Two back-to-back reads to slave1 (addr 0x1000_0004) and slave3 (addr 0x2000_0010); slave1 asserts pslverr -> first response has s_pslverr=1; second is accepted in the cycle after the first RESP with no bubble, m_paddr=0x10, s_pslverr=0.
- rst asserted during ACCESS of a write to slave0 -> next cycle all outputs 0, no s_pready; a following read completes normally.
- With APB_INTERCONNECT_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave0 never ready -> s_pready with s_pslverr=1 one cycle after the 8th ACCESS cycle; m_psel drops in the same cycle as the RESP transition.
